// File: rtl/user_uart_pkg.sv
// Shared types and constants for the user-area UART 8N1 transmitter.
package user_uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned IDX_W      = $clog2(DATA_BITS);
    localparam logic        IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/user_uart_fifo.sv
// Byte FIFO with first-word-fall-through read port and synchronous active-high reset.
module user_uart_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push_ok, pop_ok;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign level   = level_q;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/user_uart_tx.sv
// UART 8N1 transmitter: byte FIFO, frame FSM, latched baud divisor and LSB-first shifter.
module user_uart_tx
    import user_uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DIV_W = 16
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     enable,
    input  logic [DIV_W-1:0]         clk_div,
    input  logic [7:0]               tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     tx_busy,
    output logic                     tx_done,
    output logic                     ser_tx
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    uart_state_e      state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ser_tx_q, ser_tx_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;

    logic             push, pop, start_ok, bit_end;
    logic [7:0]       fifo_dout;
    logic             fifo_full, fifo_empty;
    logic [LVL_W-1:0] level, level_next;

    user_uart_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (push),
        .pop   (pop),
        .din   (tx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign push     = tx_valid && ready_q && !fifo_full;
    assign start_ok = enable && !fifo_empty;
    assign bit_end  = (cnt_q == '0);

    // Frame sequencing; the divisor is captured once per frame at the pop.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_START;
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    div_d   = clk_div;
                    cnt_d   = clk_div;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    cnt_d   = div_q;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d   = div_q;
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    done_d = 1'b1;
                    if (start_ok) begin
                        state_d = ST_START;
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        div_d   = clk_div;
                        cnt_d   = clk_div;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level follows the current state one cycle later, like the other status flops.
    always_comb begin
        ser_tx_d = IDLE_LEVEL;
        unique case (state_q)
            ST_START: ser_tx_d = 1'b0;
            ST_DATA:  ser_tx_d = shift_q[0];
            default:  ser_tx_d = IDLE_LEVEL;
        endcase
        busy_d     = (state_d != ST_IDLE);
        level_next = level + LVL_W'(push) - LVL_W'(pop);
        ready_d    = (level_next != LVL_W'(DEPTH));
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            div_q    <= '0;
            cnt_q    <= '0;
            shift_q  <= '0;
            idx_q    <= '0;
            ser_tx_q <= IDLE_LEVEL;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            ser_tx_q <= ser_tx_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
        end
    end

    assign ser_tx     = ser_tx_q;
    assign tx_done    = done_q;
    assign tx_busy    = busy_q;
    assign tx_ready   = ready_q;
    assign fifo_level = level;

endmodule

// File: tb/tb_user_uart_tx.sv
// Directed self-checking bench for user_uart_tx; samples 1 ns after each rising edge.
module tb_user_uart_tx;
    import user_uart_pkg::*;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        enable;
    logic [15:0] clk_div;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [2:0]  fifo_level;
    logic        tx_busy;
    logic        tx_done;
    logic        ser_tx;

    int vectors = 0;
    int miscompares = 0;

    user_uart_tx #(.DEPTH(4), .DIV_W(16)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .enable     (enable),
        .clk_div    (clk_div),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .fifo_level (fifo_level),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .ser_tx     (ser_tx)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Line level for frame position pos: 0 start, 1..8 data LSB first, 9 stop.
    function automatic logic exp_line(input logic [7:0] b, input int unsigned pos);
        if (pos == 0) return 1'b0;
        if (pos >= 9) return 1'b1;
        return b[pos-1];
    endfunction

    task automatic test_reset();
        wb_rst_i = 1'b1; enable = 1'b0; clk_div = 16'd3; tx_data = 8'h00; tx_valid = 1'b0;
        repeat (3) tick();
        vectors++; if (ser_tx !== 1'b1) begin miscompares++; $display("FAIL rst_ser_tx: got %b want 1", ser_tx); end
        vectors++; if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready_held: got %b want 0", tx_ready); end
        vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
        vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", tx_busy); end
        vectors++; if (tx_done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", tx_done); end
        wb_rst_i = 1'b0;
        tick();
        vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_ready: got %b want 1", tx_ready); end
        vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL post_rst_level: got %0d want 0", fifo_level); end
        for (int i = 0; i < 100; i++) begin
            tick();
            vectors++; if (ser_tx !== 1'b1) begin miscompares++; $display("FAIL idle_line[%0d]: got %b want 1", i, ser_tx); end
        end
    endtask

    task automatic test_single_frame();
        enable = 1'b1; clk_div = 16'd3;
        tx_data = 8'hA5; tx_valid = 1'b1;
        tick();  // accepting edge
        tx_valid = 1'b0;
        vectors++; if (fifo_level !== 3'd1) begin miscompares++; $display("FAIL single_level: got %0d want 1", fifo_level); end
        vectors++; if (ser_tx !== 1'b1) begin miscompares++; $display("FAIL single_lat0: got %b want 1", ser_tx); end
        tick();
        vectors++; if (ser_tx !== 1'b1) begin miscompares++; $display("FAIL single_lat1: got %b want 1", ser_tx); end
        vectors++; if (tx_busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b want 1", tx_busy); end
        for (int i = 0; i < FRAME_BITS * 4; i++) begin
            tick();
            vectors++; if (ser_tx !== exp_line(8'hA5, i / 4)) begin miscompares++; $display("FAIL single_line[%0d]: got %b want %b", i, ser_tx, exp_line(8'hA5, i / 4)); end
            vectors++; if (tx_done !== (i == 39)) begin miscompares++; $display("FAIL single_done[%0d]: got %b want %b", i, tx_done, i == 39); end
        end
        tick();
        vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL single_end_busy: got %b want 0", tx_busy); end
        vectors++; if (tx_done !== 1'b0) begin miscompares++; $display("FAIL single_end_done: got %b want 0", tx_done); end
        vectors++; if (ser_tx !== 1'b1) begin miscompares++; $display("FAIL single_end_line: got %b want 1", ser_tx); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        enable = 1'b0; clk_div = 16'd3;
        for (int k = 0; k < 4; k++) begin
            tx_data = 8'(k + 1); tx_valid = 1'b1;
            tick();
            vectors++; if (fifo_level !== 3'(k + 1)) begin miscompares++; $display("FAIL b2b_fill_level[%0d]: got %0d want %0d", k, fifo_level, k + 1); end
            vectors++; if (tx_ready !== (k < 3)) begin miscompares++; $display("FAIL b2b_fill_ready[%0d]: got %b want %b", k, tx_ready, k < 3); end
        end
        tx_data = 8'h05;
        repeat (3) tick();
        vectors++; if (fifo_level !== 3'd4) begin miscompares++; $display("FAIL b2b_full_level: got %0d want 4", fifo_level); end
        vectors++; if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_full_ready: got %b want 0", tx_ready); end
        enable = 1'b1;
        tick();  // first pop
        vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_after_pop: got %b want 1", tx_ready); end
        vectors++; if (fifo_level !== 3'd3) begin miscompares++; $display("FAIL b2b_level_after_pop: got %0d want 3", fifo_level); end
        for (int i = 0; i < 5 * FRAME_BITS * 4; i++) begin
            tick();
            if (i == 0) begin
                tx_valid = 1'b0;
                vectors++; if (fifo_level !== 3'd4) begin miscompares++; $display("FAIL b2b_fifth_push: got %0d want 4", fifo_level); end
            end
            b = 8'(i / 40 + 1);
            vectors++; if (ser_tx !== exp_line(b, (i % 40) / 4)) begin miscompares++; $display("FAIL b2b_line[%0d]: got %b want %b", i, ser_tx, exp_line(b, (i % 40) / 4)); end
            vectors++; if (tx_done !== (i % 40 == 39)) begin miscompares++; $display("FAIL b2b_done[%0d]: got %b want %b", i, tx_done, i % 40 == 39); end
        end
        tick();
        vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL b2b_end_busy: got %b want 0", tx_busy); end
        vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL b2b_end_level: got %0d want 0", fifo_level); end
    endtask

    task automatic test_div_change();
        logic w;
        enable = 1'b0; clk_div = 16'd3;
        tx_data = 8'h3C; tx_valid = 1'b1; tick();
        tx_data = 8'hC3; tick();
        tx_valid = 1'b0; enable = 1'b1;
        tick();
        for (int i = 0; i < 120; i++) begin
            tick();
            if (i < 40) w = exp_line(8'h3C, i / 4);
            else        w = exp_line(8'hC3, (i - 40) / 8);
            vectors++; if (ser_tx !== w) begin miscompares++; $display("FAIL div_line[%0d]: got %b want %b", i, ser_tx, w); end
            vectors++; if (tx_done !== (i == 39 || i == 119)) begin miscompares++; $display("FAIL div_done[%0d]: got %b want %b", i, tx_done, i == 39 || i == 119); end
            if (i == 20) clk_div = 16'd7;
        end
        tick();
        vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL div_end_busy: got %b want 0", tx_busy); end
        clk_div = 16'd3;
    endtask

    task automatic test_enable_drop();
        enable = 1'b0; clk_div = 16'd3;
        tx_data = 8'h55; tx_valid = 1'b1; tick();
        tx_data = 8'h0F; tick();
        tx_valid = 1'b0; enable = 1'b1;
        tick();
        for (int i = 0; i < 40; i++) begin
            tick();
            vectors++; if (ser_tx !== exp_line(8'h55, i / 4)) begin miscompares++; $display("FAIL en_line[%0d]: got %b want %b", i, ser_tx, exp_line(8'h55, i / 4)); end
            if (i == 12) enable = 1'b0;
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++; if (ser_tx !== 1'b1) begin miscompares++; $display("FAIL en_hold_line[%0d]: got %b want 1", i, ser_tx); end
            vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL en_hold_busy[%0d]: got %b want 0", i, tx_busy); end
            vectors++; if (fifo_level !== 3'd1) begin miscompares++; $display("FAIL en_hold_level[%0d]: got %0d want 1", i, fifo_level); end
        end
        enable = 1'b1;
        tick();
        vectors++; if (tx_busy !== 1'b1) begin miscompares++; $display("FAIL en_restart_busy: got %b want 1", tx_busy); end
        vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL en_restart_level: got %0d want 0", fifo_level); end
        for (int i = 0; i < 40; i++) begin
            tick();
            vectors++; if (ser_tx !== exp_line(8'h0F, i / 4)) begin miscompares++; $display("FAIL en_frame2[%0d]: got %b want %b", i, ser_tx, exp_line(8'h0F, i / 4)); end
        end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        enable = 1'b0; clk_div = 16'd3;
        tx_data = 8'h2C; tx_valid = 1'b1; tick();
        tx_data = 8'h22; tick();
        tx_data = 8'h33; tick();
        tx_valid = 1'b0; enable = 1'b1;
        tick();
        for (int i = 0; i <= 21; i++) tick();
        // Data bit 4 of 0x2C is 0, so the reset has a visible effect on the line.
        vectors++; if (ser_tx !== 1'b0) begin miscompares++; $display("FAIL rmf_bit4: got %b want 0", ser_tx); end
        vectors++; if (fifo_level !== 3'd2) begin miscompares++; $display("FAIL rmf_queued: got %0d want 2", fifo_level); end
        wb_rst_i = 1'b1;
        tick();
        vectors++; if (ser_tx !== 1'b1) begin miscompares++; $display("FAIL rmf_line: got %b want 1", ser_tx); end
        vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL rmf_level: got %0d want 0", fifo_level); end
        vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL rmf_busy: got %b want 0", tx_busy); end
        vectors++; if (tx_done !== 1'b0) begin miscompares++; $display("FAIL rmf_done: got %b want 0", tx_done); end
        vectors++; if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL rmf_ready: got %b want 0", tx_ready); end
        tick();
        wb_rst_i = 1'b0;
        tick();
        vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL rmf_ready_after: got %b want 1", tx_ready); end
        for (int i = 0; i < 60; i++) begin
            tick();
            vectors++; if (ser_tx !== 1'b1) begin miscompares++; $display("FAIL rmf_idle_line[%0d]: got %b want 1", i, ser_tx); end
            vectors++; if (tx_done !== 1'b0) begin miscompares++; $display("FAIL rmf_idle_done[%0d]: got %b want 0", i, tx_done); end
            vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL rmf_idle_busy[%0d]: got %b want 0", i, tx_busy); end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_div_change();
        test_enable_drop();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
